// File: rtl/concurrent_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO and its pointer controller.
package concurrent_fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned ADDR_WIDTH = 4;

  // Pointers carry one extra wrap bit above the memory index.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/concurrent_fifo_ptr_ctrl.sv
// Read/write pointer registers with wrap-bit full/empty decode and request qualification.
module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_WIDTH = concurrent_fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_req_i,
  input  logic                  rd_req_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  wr_accept_o,
  output logic                  rd_accept_o,
  output logic                  full_o,
  output logic                  empty_o
);
  import concurrent_fifo_pkg::*;

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Flags decode straight from registered pointers; requests are gated by
  // the current flags, so a read never frees a slot for a same-cycle write.
  always_comb begin
    empty_o     = (wr_ptr_q == rd_ptr_q);
    full_o      = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    wr_accept_o = wr_req_i && !full_o;
    rd_accept_o = rd_req_i && !empty_o;
    wr_ptr_d    = wr_accept_o ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = rd_accept_o ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_addr_o = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr_o = rd_ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/concurrent_fifo_top.sv
// Single-clock FIFO: register-array storage with a registered read-data port.
module concurrent_fifo_top #(
  parameter int unsigned DATA_WIDTH = concurrent_fifo_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = concurrent_fifo_pkg::DEPTH,
  parameter int unsigned ADDR_WIDTH = concurrent_fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  wr_accept, rd_accept;

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr_ctrl (
    .clk_i       (clk),
    .rst_ni      (reset),
    .wr_req_i    (write_en),
    .rd_req_i    (read_en),
    .wr_addr_o   (wr_addr),
    .rd_addr_o   (rd_addr),
    .wr_accept_o (wr_accept),
    .rd_accept_o (rd_accept),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_addr] <= write_data;
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    if (rd_accept) begin
      read_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_concurrent_fifo_top.sv
// Scoreboard bench for concurrent_fifo_top: queue model of contents, per-cycle data/flag checks.
module tb_concurrent_fifo_top;

  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          full;
  logic          empty;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_rd = '0;
  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  concurrent_fifo_top #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .read_en    (read_en),
    .write_data (write_data),
    .read_data  (read_data),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".rdata"}, 32'(read_data), 32'(exp_rd));
    check_eq({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
    check_eq({tag, ".full"},  32'(full),  32'(sb_q.size() == DEPTH));
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic do_cycle(input string tag, input logic we, input logic re, input logic [DW-1:0] wd);
    bit w_ok;
    bit r_ok;
    @(negedge clk);
    write_en   = we;
    read_en    = re;
    write_data = wd;
    w_ok = we && (sb_q.size() != DEPTH);
    r_ok = re && (sb_q.size() != 0);
    if (r_ok) exp_rd = sb_q.pop_front();
    if (w_ok) sb_q.push_back(wd);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    check_state(tag);
  endtask

  initial begin
    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    reset = 1'b1;
    do_cycle("rel_idle", 1'b0, 1'b0, 8'h00);
    do_cycle("rel_idle2", 1'b0, 1'b0, 8'h00);

    // 2. basic ordering with single-cycle pulses
    do_cycle("wr_a1", 1'b1, 1'b0, 8'hA1);
    do_cycle("gap", 1'b0, 1'b0, 8'h00);
    do_cycle("wr_b2", 1'b1, 1'b0, 8'hB2);
    do_cycle("gap", 1'b0, 1'b0, 8'h00);
    do_cycle("wr_c3", 1'b1, 1'b0, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      do_cycle("rd_basic", 1'b0, 1'b1, 8'h00);
      do_cycle("rd_hold", 1'b0, 1'b0, 8'h00);
    end

    // 3. fill, overflow, drain
    for (int i = 0; i < 16; i++) do_cycle("fill", 1'b1, 1'b0, 8'(i));
    do_cycle("ovf_ff", 1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 16; i++) do_cycle("drain", 1'b0, 1'b1, 8'h00);

    // 4. underflow: read_data must stay 0F
    do_cycle("udf1", 1'b0, 1'b1, 8'h00);
    do_cycle("udf2", 1'b0, 1'b1, 8'h00);
    check_eq("udf_hold_0f", 32'(read_data), 32'h0F);

    // 5. simultaneous access
    do_cycle("wr_55", 1'b1, 1'b0, 8'h55);
    do_cycle("rw_aa", 1'b1, 1'b1, 8'hAA);
    do_cycle("rd_aa", 1'b0, 1'b1, 8'h00);
    do_cycle("udf_wr", 1'b1, 1'b1, 8'h3C);
    do_cycle("rd_3c", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) do_cycle("fill2", 1'b1, 1'b0, 8'(8'h80 + i));
    do_cycle("rw_full", 1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 15; i++) do_cycle("drain2", 1'b0, 1'b1, 8'h00);

    // 6. wrap across many pointer laps, then mid-cycle reset
    for (int i = 0; i < 40; i++) begin
      do_cycle("wrap_wr", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      do_cycle("wrap_rd", 1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 5; i++) do_cycle("pre_rst", 1'b1, 1'b0, 8'(8'h60 + i));
    do_cycle("pre_rst_rd", 1'b0, 1'b1, 8'h00);
    #2;
    reset = 1'b0;
    sb_q.delete();
    exp_rd = '0;
    #1;
    check_state("async_rst");
    @(negedge clk);
    reset = 1'b1;
    do_cycle("post_rst_wr", 1'b1, 1'b0, 8'h7E);
    do_cycle("post_rst_rd", 1'b0, 1'b1, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
